clint_timer_sched: RTL and testbench



---
 rtl/clint_timer_sched.sv | 142 ++++++++++++++
 tb/tb_clint_timer_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer_sched.sv
// Multiplexes NCH software timer channels onto the CLINT mtimecmp register.
// Scans a deadline table for the earliest armed channel and programs mtimecmp hi/lo/hi.
module clint_timer_sched #(
  parameter int          NCH           = 4,
  parameter int          CHW           = 2,
  parameter logic [31:0] MTIMECMP_ADDR = 32'h9000_0008
) (
  input  logic           clk,
  input  logic           resetb,
  input  logic           arm_valid,
  input  logic [CHW-1:0] arm_ch,
  input  logic [63:0]    arm_deadline,
  input  logic           disarm_valid,
  input  logic [CHW-1:0] disarm_ch,
  input  logic [NCH-1:0] pend_clr,
  output logic [NCH-1:0] irq_pend,
  output logic [NCH-1:0] armed,
  output logic           busy,
  output logic           wready,
  input  logic           wvalid,
  output logic [31:0]    waddr,
  output logic [31:0]    wdata,
  output logic [3:0]     wstrb,
  input  logic           timer_irq
);

  typedef enum logic [2:0] {SCAN, WR_HI0, WR_LO, WR_HI1, SETTLE, WAIT} state_t;

  state_t         state, state_nx;
  logic [63:0]    deadline [NCH];
  logic           dirty;
  logic [CHW-1:0] idx;
  logic [CHW-1:0] cur_ch;
  logic           cur_valid;
  logic [63:0]    min_dl;
  logic           settle_cnt;

  logic           arm_hit, disarm_hit, last_idx, fire, pend_set, scan_take;
  logic [63:0]    tgt;
  logic [NCH-1:0] armed_nx, pend_mask;
  logic           wready_nx;
  logic [31:0]    waddr_nx, wdata_nx;

  assign arm_hit    = arm_valid && (32'(arm_ch) < NCH);
  assign disarm_hit = disarm_valid && (32'(disarm_ch) < NCH);
  assign last_idx   = (32'(idx) == NCH - 1);
  assign tgt        = cur_valid ? min_dl : '1;
  assign fire       = (state == WAIT) && timer_irq && cur_valid;
  // A same-cycle arm of the expiring channel supersedes the expiry.
  assign pend_set   = fire && !(arm_hit && (arm_ch == cur_ch));
  assign scan_take  = armed[idx] && (!cur_valid || (deadline[idx] < min_dl));
  assign busy       = (state != WAIT);
  assign wstrb      = 4'hF;

  always_comb begin
    armed_nx  = armed;
    pend_mask = '0;
    if (pend_set) begin
      armed_nx[cur_ch]  = 1'b0;
      pend_mask[cur_ch] = 1'b1;
    end
    if (disarm_hit) armed_nx[disarm_ch] = 1'b0;
    if (arm_hit)    armed_nx[arm_ch]    = 1'b1;
  end

  always_comb begin
    state_nx  = state;
    wready_nx = 1'b0;
    waddr_nx  = waddr;
    wdata_nx  = wdata;
    case (state)
      SCAN:    if (last_idx) state_nx = WR_HI0;
      WR_HI0:  if (wready && wvalid) state_nx = WR_LO;
      WR_LO:   if (wready && wvalid) state_nx = WR_HI1;
      WR_HI1:  if (wready && wvalid) state_nx = SETTLE;
      SETTLE:  if (settle_cnt) state_nx = WAIT;
      WAIT:    if (fire || dirty) state_nx = SCAN;
      default: state_nx = SCAN;
    endcase
    // Write port outputs are registered alongside the state they belong to.
    case (state_nx)
      WR_HI0: begin
        wready_nx = 1'b1;
        waddr_nx  = MTIMECMP_ADDR + 32'd4;
        wdata_nx  = '1;
      end
      WR_LO: begin
        wready_nx = 1'b1;
        waddr_nx  = MTIMECMP_ADDR;
        wdata_nx  = tgt[31:0];
      end
      WR_HI1: begin
        wready_nx = 1'b1;
        waddr_nx  = MTIMECMP_ADDR + 32'd4;
        wdata_nx  = tgt[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= SCAN;
      dirty      <= 1'b1;
      idx        <= '0;
      cur_ch     <= '0;
      cur_valid  <= 1'b0;
      min_dl     <= '0;
      settle_cnt <= 1'b0;
      armed      <= '0;
      irq_pend   <= '0;
      wready     <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      for (int unsigned i = 0; i < NCH; i++) deadline[i] <= '0;
    end else begin
      state      <= state_nx;
      wready     <= wready_nx;
      waddr      <= waddr_nx;
      wdata      <= wdata_nx;
      armed      <= armed_nx;
      irq_pend   <= (irq_pend & ~pend_clr) | pend_mask;
      settle_cnt <= (state == SETTLE) ? !settle_cnt : 1'b0;
      // First scan cycle consumes dirty; new requests in that cycle re-set it.
      dirty <= (dirty && !((state == SCAN) && (idx == '0))) || arm_hit || disarm_hit;
      if (arm_hit) deadline[arm_ch] <= arm_deadline;
      if (state == SCAN) begin
        idx <= last_idx ? '0 : idx + 1'b1;
        if (idx == '0) begin
          cur_valid <= armed[idx];
          cur_ch    <= idx;
          min_dl    <= deadline[idx];
        end else if (scan_take) begin
          cur_valid <= 1'b1;
          cur_ch    <= idx;
          min_dl    <= deadline[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_clint_timer_sched.sv
// Directed bench for clint_timer_sched: vector table of arm/disarm requests plus
// hand-written expiry, stall and reset sequences against a logged CLINT write port.
module tb_clint_timer_sched;

  localparam int          NCH  = 4;
  localparam logic [31:0] A    = 32'h9000_0008;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        arm_valid = 1'b0;
  logic [1:0]  arm_ch = '0;
  logic [63:0] arm_deadline = '0;
  logic        disarm_valid = 1'b0;
  logic [1:0]  disarm_ch = '0;
  logic [3:0]  pend_clr = '0;
  logic [3:0]  irq_pend, armed;
  logic        busy, wready;
  logic        wvalid = 1'b1;
  logic [31:0] waddr, wdata;
  logic [3:0]  wstrb;
  logic        timer_irq = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [63:0] wlog[$];

  typedef struct {
    logic        arm;
    logic [1:0]  ch;
    logic [63:0] dl;
    logic        disarm;
    logic [1:0]  dch;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic [3:0]  exp_armed;
  } vec_t;

  vec_t vecs[11];

  clint_timer_sched #(.NCH(4), .CHW(2), .MTIMECMP_ADDR(32'h9000_0008)) dut (
    .clk(clk), .resetb(resetb),
    .arm_valid(arm_valid), .arm_ch(arm_ch), .arm_deadline(arm_deadline),
    .disarm_valid(disarm_valid), .disarm_ch(disarm_ch),
    .pend_clr(pend_clr), .irq_pend(irq_pend), .armed(armed), .busy(busy),
    .wready(wready), .wvalid(wvalid), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (resetb && wready && wvalid) wlog.push_back({waddr, wdata});

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(input int budget, output int lat);
    lat = 0;
    while (wlog.size() < 3 && lat < budget) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk({name, " busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_seq(input string name, input logic [31:0] lo, input logic [31:0] hi);
    logic [63:0] exp [3];
    exp[0] = {A + 32'd4, ONES};
    exp[1] = {A, lo};
    exp[2] = {A + 32'd4, hi};
    chk({name, " nwrites"}, 64'(wlog.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s write%0d", name, k), (k < wlog.size()) ? wlog[k] : 64'hx, exp[k]);
    wlog.delete();
  endtask

  task automatic apply(input string name, input vec_t v);
    int lat;
    wlog.delete();
    arm_valid = v.arm; arm_ch = v.ch; arm_deadline = v.dl;
    disarm_valid = v.disarm; disarm_ch = v.dch;
    tick();
    arm_valid = 1'b0; disarm_valid = 1'b0;
    wait_writes(40, lat);
    chk({name, " latency"}, 64'(lat), 64'(NCH + 4));
    check_seq(name, v.exp_lo, v.exp_hi);
    wait_idle(name);
    chk({name, " armed"}, {60'd0, armed}, {60'd0, v.exp_armed});
  endtask

  task automatic fire(input logic [3:0] clr, input logic do_arm, input logic [1:0] ch,
                      input logic [63:0] dl);
    wlog.delete();
    timer_irq = 1'b1; pend_clr = clr;
    arm_valid = do_arm; arm_ch = ch; arm_deadline = dl;
    tick();
    timer_irq = 1'b0; pend_clr = '0; arm_valid = 1'b0;
  endtask

  task automatic wait_wr_lo(input string name);
    int n = 0;
    while (!(wready && waddr == A) && n < 40) begin
      tick();
      n++;
    end
    chk({name, " reached WR_LO"}, {63'd0, wready && waddr == A}, 64'd1);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{1'b1, 2'd2, 64'd100,                1'b0, 2'd0, 32'd100,  32'd0, 4'b0100};
    vecs[1]  = '{1'b1, 2'd0, 64'd300,                1'b0, 2'd0, 32'd100,  32'd0, 4'b0101};
    vecs[2]  = '{1'b1, 2'd3, 64'h2_0000_0050,        1'b0, 2'd0, 32'd100,  32'd0, 4'b1101};
    vecs[3]  = '{1'b0, 2'd0, 64'd0,                  1'b1, 2'd2, 32'd300,  32'd0, 4'b1001};
    vecs[4]  = '{1'b1, 2'd1, 64'd300,                1'b0, 2'd0, 32'd300,  32'd0, 4'b1011};
    vecs[5]  = '{1'b0, 2'd0, 64'd0,                  1'b1, 2'd0, 32'd300,  32'd0, 4'b1010};
    vecs[6]  = '{1'b0, 2'd0, 64'd0,                  1'b1, 2'd1, 32'h50,   32'd2, 4'b1000};
    vecs[7]  = '{1'b0, 2'd0, 64'd0,                  1'b1, 2'd3, ONES,     ONES,  4'b0000};
    vecs[8]  = '{1'b1, 2'd1, 64'd7,                  1'b1, 2'd1, 32'd7,    32'd0, 4'b0010};
    vecs[9]  = '{1'b1, 2'd0, 64'h1_0000_0000,        1'b1, 2'd1, 32'd0,    32'd1, 4'b0001};
    vecs[10] = '{1'b0, 2'd0, 64'd0,                  1'b1, 2'd0, ONES,     ONES,  4'b0000};

    // Reset values
    #12;
    chk("rst wready", {63'd0, wready}, 64'd0);
    chk("rst waddr", {32'd0, waddr}, 64'd0);
    chk("rst wdata", {32'd0, wdata}, 64'd0);
    chk("rst armed", {60'd0, armed}, 64'd0);
    chk("rst irq_pend", {60'd0, irq_pend}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd1);
    chk("wstrb", {60'd0, wstrb}, 64'hF);
    tick();
    resetb = 1'b1;
    wait_writes(40, lat);
    check_seq("post-reset", ONES, ONES);
    wait_idle("post-reset");

    for (int i = 0; i < 11; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Expiry with timer_irq held into SCAN: only one channel fires
    apply("f1 arm2", '{1'b1, 2'd2, 64'd100, 1'b0, 2'd0, 32'd100, 32'd0, 4'b0100});
    apply("f1 arm0", '{1'b1, 2'd0, 64'd300, 1'b0, 2'd0, 32'd100, 32'd0, 4'b0101});
    wlog.delete();
    timer_irq = 1'b1;
    tick();
    chk("f1 pend", {60'd0, irq_pend}, 64'b0100);
    chk("f1 armed", {60'd0, armed}, 64'b0001);
    tick(); tick(); tick();
    timer_irq = 1'b0;
    wait_writes(40, lat);
    check_seq("f1 resched", 32'd300, 32'd0);
    wait_idle("f1");
    chk("f1 pend hold", {60'd0, irq_pend}, 64'b0100);
    chk("f1 armed hold", {60'd0, armed}, 64'b0001);
    pend_clr = 4'b0100;
    tick();
    pend_clr = '0;
    chk("f1 pend clr", {60'd0, irq_pend}, 64'd0);

    // Equal deadlines fire in index order
    apply("f2 dis0", '{1'b0, 2'd0, 64'd0, 1'b1, 2'd0, ONES, ONES, 4'b0000});
    apply("f2 arm1", '{1'b1, 2'd1, 64'd500, 1'b0, 2'd0, 32'd500, 32'd0, 4'b0010});
    apply("f2 arm3", '{1'b1, 2'd3, 64'd500, 1'b0, 2'd0, 32'd500, 32'd0, 4'b1010});
    fire(4'b0000, 1'b0, 2'd0, 64'd0);
    chk("f2 pend a", {60'd0, irq_pend}, 64'b0010);
    chk("f2 armed a", {60'd0, armed}, 64'b1000);
    wait_writes(40, lat);
    chk("f2 resched latency", 64'(lat), 64'(NCH + 3));
    check_seq("f2 resched", 32'd500, 32'd0);
    wait_idle("f2 a");
    fire(4'b0000, 1'b0, 2'd0, 64'd0);
    chk("f2 pend b", {60'd0, irq_pend}, 64'b1010);
    chk("f2 armed b", {60'd0, armed}, 64'b0000);
    wait_writes(40, lat);
    check_seq("f2 final", ONES, ONES);
    wait_idle("f2 b");
    pend_clr = 4'b1111;
    tick();
    pend_clr = '0;
    chk("f2 pend clr", {60'd0, irq_pend}, 64'd0);

    // Write-port stall during WR_LO
    wlog.delete();
    arm_valid = 1'b1; arm_ch = 2'd0; arm_deadline = 64'h1234_5678_9ABC_DEF0;
    tick();
    arm_valid = 1'b0;
    wait_wr_lo("stall");
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d wready", k), {63'd0, wready}, 64'd1);
      chk($sformatf("stall%0d waddr", k), {32'd0, waddr}, {32'd0, A});
      chk($sformatf("stall%0d wdata", k), {32'd0, wdata}, 64'h9ABC_DEF0);
    end
    wvalid = 1'b1;
    wait_writes(40, lat);
    check_seq("stall", 32'h9ABC_DEF0, 32'h1234_5678);
    wait_idle("stall");

    // Same-cycle arm of the expiring channel wins
    apply("aw dis0", '{1'b0, 2'd0, 64'd0, 1'b1, 2'd0, ONES, ONES, 4'b0000});
    apply("aw arm2", '{1'b1, 2'd2, 64'd50, 1'b0, 2'd0, 32'd50, 32'd0, 4'b0100});
    fire(4'b0000, 1'b1, 2'd2, 64'h1_0000_0000);
    chk("aw pend", {60'd0, irq_pend}, 64'd0);
    chk("aw armed", {60'd0, armed}, 64'b0100);
    wait_writes(40, lat);
    check_seq("aw", 32'd0, 32'd1);
    wait_idle("aw");

    // Pend set beats same-cycle pend_clr
    apply("pc arm2", '{1'b1, 2'd2, 64'd50, 1'b0, 2'd0, 32'd50, 32'd0, 4'b0100});
    fire(4'b0100, 1'b0, 2'd0, 64'd0);
    chk("pc pend", {60'd0, irq_pend}, 64'b0100);
    chk("pc armed", {60'd0, armed}, 64'd0);
    wait_writes(40, lat);
    check_seq("pc", ONES, ONES);
    wait_idle("pc");
    chk("pc pend hold", {60'd0, irq_pend}, 64'b0100);

    // timer_irq with nothing armed is ignored
    fire(4'b0000, 1'b0, 2'd0, 64'd0);
    chk("nv busy", {63'd0, busy}, 64'd0);
    chk("nv pend", {60'd0, irq_pend}, 64'b0100);

    // Reset during WR_LO
    wlog.delete();
    arm_valid = 1'b1; arm_ch = 2'd1; arm_deadline = 64'h55;
    tick();
    arm_valid = 1'b0;
    wait_wr_lo("mrst");
    wvalid = 1'b0;
    #2 resetb = 1'b0;
    #1;
    chk("mrst wready", {63'd0, wready}, 64'd0);
    chk("mrst waddr", {32'd0, waddr}, 64'd0);
    chk("mrst wdata", {32'd0, wdata}, 64'd0);
    chk("mrst armed", {60'd0, armed}, 64'd0);
    chk("mrst pend", {60'd0, irq_pend}, 64'd0);
    chk("mrst busy", {63'd0, busy}, 64'd1);
    wvalid = 1'b1;
    tick(); tick();
    wlog.delete();
    resetb = 1'b1;
    wait_writes(40, lat);
    check_seq("mrst", ONES, ONES);
    wait_idle("mrst");
    chk("mrst armed after", {60'd0, armed}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
